// File: rtl/return_stack.sv
// Return-address stack for the calculator CPU: CALL pushes the PC, RET pops it.
// Overflow/underflow park the stack in FAULT until the control unit clears it.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             CLR_ERR,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic [PTR_W:0]   COUNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic             FAULT
);

  typedef enum logic {ST_OK, ST_FAULT} state_t;

  state_t             state, state_next;
  logic [PTR_W:0]     sp, sp_next;
  logic               ovf, ovf_next;
  logic               unf, unf_next;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_addr;
  logic [PTR_W-1:0]   top_idx;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               empty, full;

  assign empty   = (sp == '0);
  assign full    = (sp == (PTR_W+1)'(DEPTH));
  // sp == DEPTH truncates to 0, so the subtraction wraps to DEPTH-1 as intended.
  assign top_idx = sp[PTR_W-1:0] - PTR_W'(1);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= ST_OK;
      sp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_next;
      sp    <= sp_next;
      ovf   <= ovf_next;
      unf   <= unf_next;
    end
  end

  // Storage carries no reset; only SP decides which entries are valid.
  always_ff @(posedge CLK) begin
    if (RESET && wr_en) begin
      mem[wr_addr] <= DIN;
    end
  end

  always_comb begin
    state_next = state;
    sp_next    = sp;
    ovf_next   = ovf;
    unf_next   = unf;
    wr_en      = 1'b0;
    wr_addr    = top_idx;
    case (state)
      ST_OK: begin
        if (PUSH && POP && !empty) begin
          wr_en   = 1'b1;
          wr_addr = top_idx;
        end else if (PUSH && POP) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          sp_next    = (PTR_W+1)'(1);
          unf_next   = 1'b1;
          state_next = ST_FAULT;
        end else if (PUSH && !full) begin
          wr_en   = 1'b1;
          wr_addr = sp[PTR_W-1:0];
          sp_next = sp + (PTR_W+1)'(1);
        end else if (PUSH) begin
          ovf_next   = 1'b1;
          state_next = ST_FAULT;
        end else if (POP && !empty) begin
          sp_next = sp - (PTR_W+1)'(1);
        end else if (POP) begin
          unf_next   = 1'b1;
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (CLR_ERR) begin
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          state_next = ST_OK;
        end
      end
      default: state_next = ST_OK;
    endcase
  end

  assign DOUT      = empty ? '0 : mem[top_idx];
  assign COUNT     = sp;
  assign EMPTY     = empty;
  assign FULL      = full;
  assign OVERFLOW  = ovf;
  assign UNDERFLOW = unf;
  assign FAULT     = (state == ST_FAULT);

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: reset, push/pop, full/empty traps,
// tail-call replace and reset priority.
module tb_return_stack;

  logic        CLK = 1'b0;
  logic        RESET, PUSH, POP, CLR_ERR;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic [3:0]  COUNT;
  logic        EMPTY, FULL, OVERFLOW, UNDERFLOW, FAULT;

  int tests_run = 0;
  int tests_failed = 0;

  return_stack #(.WIDTH(16), .DEPTH(8), .PTR_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR),
    .DIN(DIN), .DOUT(DOUT), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, then return to idle just after it.
  task automatic step(input logic rst_n, input logic push, input logic pop,
                      input logic clr, input logic [15:0] din);
    RESET = rst_n; PUSH = push; POP = pop; CLR_ERR = clr; DIN = din;
    @(posedge CLK);
    #1;
    RESET = 1'b1; PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0; DIN = 16'h0000;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic push(input logic [15:0] v);
    step(1'b1, 1'b1, 1'b0, 1'b0, v);
  endtask

  initial begin
    RESET = 1'b1; PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0; DIN = 16'h0000;
    #2;

    // 1. reset state
    do_reset();
    check("rst_dout", DOUT, 0);
    check("rst_count", COUNT, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_fault", FAULT, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_unf", UNDERFLOW, 0);

    // 2. push two, pop one
    push(16'h0012);
    push(16'h6AB3);
    check("t2_count", COUNT, 2);
    check("t2_dout", DOUT, 16'h6AB3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("t2_pop_count", COUNT, 1);
    check("t2_pop_dout", DOUT, 16'h0012);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("t2_pop2_empty", EMPTY, 1);
    check("t2_pop2_dout", DOUT, 0);
    check("t2_pop2_fault", FAULT, 0);

    // 3. fill, overflow, clear
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    check("t3_full", FULL, 1);
    check("t3_count", COUNT, 8);
    check("t3_dout", DOUT, 16'h0107);
    push(16'hFFFF);
    check("t3_ovf", OVERFLOW, 1);
    check("t3_ovf_fault", FAULT, 1);
    check("t3_ovf_dout", DOUT, 16'h0107);
    check("t3_ovf_count", COUNT, 8);
    check("t3_ovf_unf", UNDERFLOW, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("t3_clr_fault", FAULT, 0);
    check("t3_clr_ovf", OVERFLOW, 0);
    check("t3_clr_dout", DOUT, 16'h0107);
    check("t3_clr_count", COUNT, 8);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("t3_pop_dout", DOUT, 16'h0106);

    // 4. underflow, pushes ignored in FAULT
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("t4_unf", UNDERFLOW, 1);
    check("t4_fault", FAULT, 1);
    check("t4_count", COUNT, 0);
    check("t4_dout", DOUT, 0);
    push(16'h5555);
    check("t4_push_ign_count", COUNT, 0);
    check("t4_push_ign_dout", DOUT, 0);
    check("t4_still_fault", FAULT, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("t4_clr_fault", FAULT, 0);
    check("t4_clr_unf", UNDERFLOW, 0);
    // CLR_ERR in OK does nothing
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("t4_clr_ok_fault", FAULT, 0);
    check("t4_clr_ok_count", COUNT, 0);

    // push+pop on empty: plain push plus underflow trap
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
    check("t4b_count", COUNT, 1);
    check("t4b_dout", DOUT, 16'h1234);
    check("t4b_unf", UNDERFLOW, 1);
    check("t4b_fault", FAULT, 1);

    // 5. tail call replaces top
    do_reset();
    push(16'h1111);
    push(16'h2222);
    push(16'h87AB);
    check("t5_pre_count", COUNT, 3);
    check("t5_pre_dout", DOUT, 16'h87AB);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h8400);
    check("t5_count", COUNT, 3);
    check("t5_dout", DOUT, 16'h8400);
    check("t5_fault", FAULT, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("t5_pop_dout", DOUT, 16'h2222);

    // 6. reset wins over push
    push(16'h3333);
    push(16'h4444);
    push(16'h5555);
    check("t6_pre_count", COUNT, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h9999);
    check("t6_count", COUNT, 0);
    check("t6_empty", EMPTY, 1);
    check("t6_dout", DOUT, 0);
    check("t6_ovf", OVERFLOW, 0);
    check("t6_unf", UNDERFLOW, 0);
    check("t6_fault", FAULT, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
